// File: rtl/ram_responder.sv
// ram_responder
// -------------
// Memory-side responder for the core's RAM port. Holds DEPTH 64-bit
// doublewords mapped at BASE_ADDR. After reset it zero-fills (with INIT_WORD)
// every entry, one per cycle, then serves reads and bit-masked writes.
//
// Parameters:
//   DEPTH      number of 64-bit doublewords (power of two, >= 16)
//   BASE_ADDR  byte address mapped to index 0
//   READ_LAT   0 = combinational read data, 1 = registered read data
//   INIT_WORD  value written to every entry by the init sweep
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous active-low reset
//   RamReadEnable   read request
//   RamReadAddr     read byte address (bit 2 selects the half-swap)
//   RamWriteEnable  write request
//   RamWriteAddr    write byte address
//   RamWriteMask    per-bit write mask, 1 = update that bit
//   RamWriteData    write data
//   RamReadData     read data
//   init_done       high once the init sweep has completed
//   addr_err        one-cycle pulse after any out-of-range access
//
// Build option:
//   RAM_FWD_EN  when defined, a read that collides with a same-cycle in-range
//               write to the same index returns the merged write value.

module ram_responder #(
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          READ_LAT  = 1,
    parameter logic [63:0] INIT_WORD = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RamReadEnable,
    input  logic [63:0] RamReadAddr,
    input  logic        RamWriteEnable,
    input  logic [63:0] RamWriteAddr,
    input  logic [63:0] RamWriteMask,
    input  logic [63:0] RamWriteData,
    output logic [63:0] RamReadData,
    output logic        init_done,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q;
    logic [63:0]   mem [DEPTH];

    logic          run;
    logic          rd_hit, wr_hit, oor;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [63:0]   wr_merged, rd_word, rd_val;

    // Below BASE_ADDR the subtraction wraps, so the explicit lower bound is
    // what rejects those addresses.
    function automatic logic in_range(input logic [63:0] addr);
        return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> 3) < 64'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] to_idx(input logic [63:0] addr);
        return AW'((addr - BASE_ADDR) >> 3);
    endfunction

    assign run    = (state_q == RUN);
    assign rd_idx = to_idx(RamReadAddr);
    assign wr_idx = to_idx(RamWriteAddr);
    assign rd_hit = run && RamReadEnable && in_range(RamReadAddr);
    assign wr_hit = run && RamWriteEnable && in_range(RamWriteAddr);

    // Read and write out of range in the same cycle still yield one pulse.
    assign oor = run && ((RamReadEnable && !in_range(RamReadAddr)) ||
                         (RamWriteEnable && !in_range(RamWriteAddr)));

    assign wr_merged = (mem[wr_idx] & ~RamWriteMask) | (RamWriteData & RamWriteMask);

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= INIT;
        else      state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (state_q == INIT && cnt_q == LAST_IDX) state_d = RUN;
    end

    // Sweep counter holds at the last index once the sweep is finished.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (state_q == INIT && cnt_q != LAST_IDX)
            cnt_q <= cnt_q + 1'b1;
    end

    // ---------------- storage ----------------
    // NOTE: the array has no reset; the init sweep establishes its contents,
    // which lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            mem[cnt_q] <= INIT_WORD;
        else if (wr_hit)
            mem[wr_idx] <= wr_merged;
    end

    // ---------------- read path ----------------
    always_comb begin
        rd_word = mem[rd_idx];
`ifdef RAM_FWD_EN
        if (wr_hit && wr_idx == rd_idx) rd_word = wr_merged;
`endif
        rd_val = '0;
        // Bit 2 set: present the upper word in [31:0] for instruction fetch.
        if (rd_hit)
            rd_val = RamReadAddr[2] ? {rd_word[31:0], rd_word[63:32]} : rd_word;
    end

    generate
        if (READ_LAT == 0) begin : g_comb_read
            assign RamReadData = rd_val;
        end else begin : g_reg_read
            // Holds its value while no read is requested.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)               RamReadData <= '0;
                else if (RamReadEnable) RamReadData <= rd_val;
            end
        end
    endgenerate

    // ---------------- status ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_done <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            init_done <= run;
            addr_err  <= oor;
        end
    end

endmodule
